// File: rtl/mem_pkg.sv
// Shared widths, opcodes and opcode helpers for the memory-access stage.
package mem_pkg;
  localparam int DW_DEF  = 8;
  localparam int AW_DEF  = 8;
  localparam int RW_DEF  = 2;
  localparam int OPW_DEF = 4;

  localparam logic [OPW_DEF-1:0] OP_NOP = 4'd0;
  localparam logic [OPW_DEF-1:0] OP_LD  = 4'd13;
  localparam logic [OPW_DEF-1:0] OP_ST  = 4'd14;
  localparam logic [OPW_DEF-1:0] OP_LDI = 4'd15;

  function automatic logic is_load(input logic [OPW_DEF-1:0] op);
    return (op == OP_LD) || (op == OP_LDI);
  endfunction
endpackage

// File: rtl/mem_access_stage_if.sv
// Execute-side handshake, dataMemory drive and register-file writeback bundle.
interface mem_access_stage_if #(
  parameter int DW  = mem_pkg::DW_DEF,
  parameter int AW  = mem_pkg::AW_DEF,
  parameter int RW  = mem_pkg::RW_DEF,
  parameter int OPW = mem_pkg::OPW_DEF
);
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_op;
  logic [RW-1:0]  in_rd;
  logic [RW-1:0]  in_rs;
  logic [DW-1:0]  in_ra;
  logic [AW-1:0]  in_addr;
  logic [OPW-1:0] op_dm;
  logic [DW-1:0]  ra_dm;
  logic [AW-1:0]  addr_dm;
  logic [DW-1:0]  dm_out;
  logic           rf_we;
  logic [RW-1:0]  rf_waddr;
  logic [DW-1:0]  rf_wdata;

  modport slave (
    input  in_valid, in_op, in_rd, in_rs, in_ra, in_addr, dm_out,
    output in_ready, op_dm, ra_dm, addr_dm, rf_we, rf_waddr, rf_wdata
  );

  modport master (
    output in_valid, in_op, in_rd, in_rs, in_ra, in_addr, dm_out,
    input  in_ready, op_dm, ra_dm, addr_dm, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/mem_wb_track.sv
// Writeback tracker: follows loads through dataMemory's read latency and
// flags stores whose source register is still waiting on a load result.
module mem_wb_track
  import mem_pkg::*;
#(
  parameter int RW  = RW_DEF,
  parameter int OPW = OPW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s1_valid,
  input  logic [OPW-1:0] s1_op,
  input  logic [RW-1:0]  s1_rd,
  input  logic [RW-1:0]  rs,
  output logic           wb_valid,
  output logic [RW-1:0]  wb_rd,
  output logic           hazard
);
  logic          wb_valid_r;
  logic [RW-1:0] wb_rd_r;
  logic          s1_load_s;

  // Writeback slot: one cycle behind issue, matching the dataMemory read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_r <= 1'b0;
      wb_rd_r    <= '0;
    end else begin
      wb_valid_r <= s1_valid && is_load(s1_op);
      wb_rd_r    <= s1_rd;
    end
  end

  // A load still in issue or in writeback has not reached the register file yet
  always_comb begin
    s1_load_s = s1_valid && is_load(s1_op);
    hazard    = (s1_load_s && (s1_rd == rs)) || (wb_valid_r && (wb_rd_r == rs));
  end

  assign wb_valid = wb_valid_r;
  assign wb_rd    = wb_rd_r;
endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues one memory op per cycle to dataMemory
// and routes its read result to register-file writeback.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int AW  = AW_DEF,
  parameter int RW  = RW_DEF,
  parameter int OPW = OPW_DEF
) (
  input logic               clk,
  input logic               rst,
  mem_access_stage_if.slave bus
);
  logic           s1_valid_r;
  logic [OPW-1:0] s1_op_r;
  logic [RW-1:0]  s1_rd_r;
  logic [DW-1:0]  s1_ra_r;
  logic [AW-1:0]  s1_addr_r;

  logic [OPW-1:0] op_clean_s;
  logic           in_ready_s;
  logic           transfer_s;
  logic           hazard_s;
  logic           wb_valid_s;
  logic [RW-1:0]  wb_rd_s;

  // Anything that is not a memory opcode travels as a harmless NOP
  always_comb begin
    case (bus.in_op)
      OP_LD, OP_ST, OP_LDI: op_clean_s = bus.in_op;
      default:              op_clean_s = OP_NOP;
    endcase
  end

  // Hold a store back while its source register awaits a load result
  always_comb begin
    if (bus.in_valid && (bus.in_op == OP_ST) && hazard_s) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = 1'b1;
    end
    transfer_s = bus.in_valid && in_ready_s;
  end

  // Issue slot: live for exactly one cycle per accepted instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_op_r    <= OP_NOP;
      s1_rd_r    <= '0;
      s1_ra_r    <= '0;
      s1_addr_r  <= '0;
    end else if (transfer_s) begin
      s1_valid_r <= 1'b1;
      s1_op_r    <= op_clean_s;
      s1_rd_r    <= bus.in_rd;
      s1_ra_r    <= bus.in_ra;
      s1_addr_r  <= bus.in_addr;
    end else begin
      s1_valid_r <= 1'b0;
      s1_op_r    <= OP_NOP;
    end
  end

  mem_wb_track #(
    .RW  (RW),
    .OPW (OPW)
  ) u_wb_track (
    .clk      (clk),
    .rst      (rst),
    .s1_valid (s1_valid_r),
    .s1_op    (s1_op_r),
    .s1_rd    (s1_rd_r),
    .rs       (bus.in_rs),
    .wb_valid (wb_valid_s),
    .wb_rd    (wb_rd_s),
    .hazard   (hazard_s)
  );

  assign bus.in_ready = in_ready_s;
  assign bus.op_dm    = s1_valid_r ? s1_op_r : OP_NOP;
  assign bus.ra_dm    = s1_ra_r;
  assign bus.addr_dm  = s1_addr_r;
  assign bus.rf_we    = wb_valid_s;
  assign bus.rf_waddr = wb_rd_s;
  // Read data arrives late in the cycle; registering it would cost a cycle of latency
  assign bus.rf_wdata = bus.dm_out;
endmodule
